step_pulse_gen: RTL and testbench

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

---
 rtl/step_pulse_gen.sv | 168 ++++++++++++++++
 tb/tb_step_pulse_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// Button front end for an up/down counter: synchronizes and debounces three raw
// buttons, then turns up/down presses into step pulses with auto-repeat plus a clear pulse.
module step_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_RATE     = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic up_btn,
    input  logic down_btn,
    input  logic clr_btn,
    output logic up_count_enable,
    output logic down_count_enable,
    output logic clear
);

    localparam int unsigned NBTN    = 3;
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        IDLE,
        UP_DELAY,
        UP_REPEAT,
        DN_DELAY,
        DN_REPEAT,
        LOCK
    } state_t;

    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync_meta;
    logic [NBTN-1:0] sync;
    logic [NBTN-1:0] db;

    logic db_up;
    logic db_dn;
    logic db_clr;
    logic db_clr_d;
    logic clr_edge;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             step_up;
    logic             step_dn;

    assign raw = {clr_btn, down_btn, up_btn};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
        end
    end

    // Level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    for (genvar g = 0; g < NBTN; g++) begin : g_debounce
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync[g] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                lvl <= sync[g];
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign db[g] = lvl;
    end

    assign db_up    = db[0];
    assign db_dn    = db[1];
    assign db_clr   = db[2];
    assign clr_edge = db_clr & ~db_clr_d;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        case (state)
            IDLE: begin
                if (db_up && db_dn) begin
                    state_nxt = LOCK;
                end else if (db_up) begin
                    state_nxt = UP_DELAY;
                    step_up   = 1'b1;
                    timer_nxt = DELAY_LOAD;
                end else if (db_dn) begin
                    state_nxt = DN_DELAY;
                    step_dn   = 1'b1;
                    timer_nxt = DELAY_LOAD;
                end
            end
            UP_DELAY, UP_REPEAT: begin
                if (db_dn) begin
                    state_nxt = LOCK;
                end else if (!db_up) begin
                    state_nxt = IDLE;
                end else if (timer == '0) begin
                    state_nxt = UP_REPEAT;
                    step_up   = 1'b1;
                    timer_nxt = RATE_LOAD;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            DN_DELAY, DN_REPEAT: begin
                if (db_up) begin
                    state_nxt = LOCK;
                end else if (!db_dn) begin
                    state_nxt = IDLE;
                end else if (timer == '0) begin
                    state_nxt = DN_REPEAT;
                    step_dn   = 1'b1;
                    timer_nxt = RATE_LOAD;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            LOCK: begin
                if (!db_up && !db_dn) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A clear drops any step issued in the same cycle; the FSM still advances.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state             <= IDLE;
            timer             <= '0;
            db_clr_d          <= 1'b0;
            clear             <= 1'b0;
            up_count_enable   <= 1'b0;
            down_count_enable <= 1'b0;
        end else begin
            state             <= state_nxt;
            timer             <= timer_nxt;
            db_clr_d          <= db_clr;
            clear             <= clr_edge;
            up_count_enable   <= step_up & ~clr_edge;
            down_count_enable <= step_dn & ~clr_edge;
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: directed scenarios with literal timing pins, then random
// button activity, all checked every cycle against a behavioural press/hold model.
module tb_step_pulse_gen;

    localparam int DB = 16;
    localparam int RD = 64;
    localparam int RR = 8;

    logic clk      = 1'b0;
    logic n_rst    = 1'b1;
    logic up_btn   = 1'b0;
    logic down_btn = 1'b0;
    logic clr_btn  = 1'b0;
    logic up_count_enable;
    logic down_count_enable;
    logic clear;

    int total  = 0;
    int bad    = 0;
    int edge_n = 0;
    bit cmp_en = 1'b0;
    int up_log[$];
    int dn_log[$];
    int clr_log[$];

    step_pulse_gen #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .up_btn           (up_btn),
        .down_btn         (down_btn),
        .clr_btn          (clr_btn),
        .up_count_enable  (up_count_enable),
        .down_count_enable(down_count_enable),
        .clear            (clear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    // Behavioural model: buttons indexed 0=up, 1=down, 2=clear.
    bit raw_q[3];
    bit syn[3];
    bit dbl[3];
    int run[3];
    bit lock;
    int dir;        // 0 none, 1 up held, 2 down held
    int k;          // edges since the first step of the current hold
    bit clr_db_d;
    bit exp_up, exp_dn, exp_clr;

    always @(posedge clk or negedge n_rst) begin
        bit raw[3];
        bit old_db[3];
        bit pu, pd, mine, other;
        if (!n_rst) begin
            for (int b = 0; b < 3; b++) begin
                raw_q[b] = 0; syn[b] = 0; dbl[b] = 0; run[b] = 0;
            end
            lock = 0; dir = 0; k = 0; clr_db_d = 0;
            exp_up = 0; exp_dn = 0; exp_clr = 0;
        end else begin
            raw[0] = up_btn; raw[1] = down_btn; raw[2] = clr_btn;
            old_db = dbl;
            for (int b = 0; b < 3; b++) begin
                if (syn[b] != dbl[b]) begin
                    run[b]++;
                    if (run[b] == DB) begin
                        dbl[b] = syn[b];
                        run[b] = 0;
                    end
                end else begin
                    run[b] = 0;
                end
                syn[b]   = raw_q[b];
                raw_q[b] = raw[b];
            end
            pu = 0; pd = 0;
            if (lock) begin
                if (!old_db[0] && !old_db[1]) lock = 0;
            end else if (dir == 0) begin
                if (old_db[0] && old_db[1]) lock = 1;
                else if (old_db[0]) begin dir = 1; k = 0; pu = 1; end
                else if (old_db[1]) begin dir = 2; k = 0; pd = 1; end
            end else begin
                mine  = (dir == 1) ? old_db[0] : old_db[1];
                other = (dir == 1) ? old_db[1] : old_db[0];
                if (other) begin
                    lock = 1; dir = 0;
                end else if (!mine) begin
                    dir = 0;
                end else begin
                    k++;
                    if (k == RD || (k > RD && (k - RD) % RR == 0)) begin
                        if (dir == 1) pu = 1; else pd = 1;
                    end
                end
            end
            exp_clr  = old_db[2] && !clr_db_d;
            clr_db_d = old_db[2];
            exp_up   = pu && !exp_clr;
            exp_dn   = pd && !exp_clr;
        end
    end

    task automatic chk(input string name, input integer act, input integer exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int off(input int q[$], input int i, input int base);
        return (q.size() > i) ? q[i] - base : -1;
    endfunction

    function automatic int has(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cycle_outputs", {up_count_enable, down_count_enable, clear},
                {exp_up, exp_dn, exp_clr});
            chk("step_exclusive", up_count_enable & down_count_enable, 0);
            if (up_count_enable)   up_log.push_back(edge_n);
            if (down_count_enable) dn_log.push_back(edge_n);
            if (clear)             clr_log.push_back(edge_n);
        end
    end

    task automatic wait_until(input int e);
        while (edge_n + 1 < e) @(negedge clk);
    endtask

    task automatic quiet(input int n);
        up_btn = 0; down_btn = 0; clr_btn = 0;
        repeat (n) @(negedge clk);
        up_log.delete(); dn_log.delete(); clr_log.delete();
    endtask

    int base, b2, len, mode;

    initial begin
        #1 n_rst = 1'b0;
        #1 chk("reset_outputs", {up_count_enable, down_count_enable, clear}, 0);
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b1;
        quiet(5);

        // Single clean press, released before the first repeat.
        base = edge_n + 1; up_btn = 1;
        wait_until(base + 30); up_btn = 0;
        wait_until(base + 90);
        chk("t1_up_count", up_log.size(), 1);
        chk("t1_up_offset", off(up_log, 0, base), 18);
        chk("t1_no_other", dn_log.size() + clr_log.size(), 0);
        quiet(20);

        // Bouncing button never settles long enough.
        base = edge_n + 1; up_btn = 1;
        for (int i = 1; i < 8; i++) begin
            wait_until(base + 5 * i); up_btn = ~up_btn;
        end
        wait_until(base + 40); up_btn = 0;
        wait_until(base + 100);
        chk("t2_no_pulses", up_log.size() + dn_log.size() + clr_log.size(), 0);
        quiet(20);

        // Down held into auto-repeat.
        base = edge_n + 1; down_btn = 1;
        wait_until(base + 120); down_btn = 0;
        wait_until(base + 170);
        chk("t3_dn_count", dn_log.size(), 8);
        chk("t3_dn_first", off(dn_log, 0, base), 18);
        chk("t3_dn_repeat1", off(dn_log, 1, base), 82);
        chk("t3_dn_repeat2", off(dn_log, 2, base), 90);
        chk("t3_dn_last", off(dn_log, 7, base), 130);
        chk("t3_no_up", up_log.size(), 0);
        quiet(20);

        // Both pressed together locks out steps until both are released.
        base = edge_n + 1; up_btn = 1; down_btn = 1;
        wait_until(base + 50); up_btn = 0;
        wait_until(base + 100); down_btn = 0;
        wait_until(base + 160);
        chk("t4_locked", up_log.size() + dn_log.size(), 0);
        b2 = edge_n + 1; up_btn = 1;
        wait_until(b2 + 30); up_btn = 0;
        wait_until(b2 + 60);
        chk("t4_after_lock", off(up_log, 0, b2), 18);
        quiet(20);

        // Clear landing on a repeat slot suppresses that step.
        base = edge_n + 1; up_btn = 1;
        wait_until(base + 72); clr_btn = 1;
        wait_until(base + 110); up_btn = 0;
        wait_until(base + 112); clr_btn = 0;
        wait_until(base + 170);
        chk("t5_clr_count", clr_log.size(), 1);
        chk("t5_clr_offset", off(clr_log, 0, base), 90);
        chk("t5_step_dropped", has(up_log, base + 90), 0);
        chk("t5_next_repeat", has(up_log, base + 98), 1);
        chk("t5_up_count", up_log.size(), 6);
        quiet(20);

        // Reset during repeat with the button still held.
        base = edge_n + 1; up_btn = 1;
        wait_until(base + 99);
        chk("t6_pulse_before_reset", up_count_enable, 1);
        #2 n_rst = 1'b0;
        #1 chk("t6_reset_async", {up_count_enable, down_count_enable, clear}, 0);
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b1;
        b2 = edge_n + 1;
        up_log.delete();
        wait_until(b2 + 30);
        chk("t6_after_reset", off(up_log, 0, b2), 18);
        quiet(40);

        // Random activity checked only by the cycle model.
        for (int s = 0; s < 70; s++) begin
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                @(negedge clk);
                #2 n_rst = 1'b0;
                repeat (2) @(negedge clk);
                #2 n_rst = 1'b1;
            end else if (mode <= 2) begin
                len = $urandom_range(5, 40);
                repeat (len) begin
                    @(negedge clk);
                    up_btn   = $urandom_range(0, 1);
                    down_btn = $urandom_range(0, 3) == 0;
                    clr_btn  = $urandom_range(0, 1);
                end
            end else begin
                @(negedge clk);
                up_btn   = $urandom_range(0, 9) < 4;
                down_btn = $urandom_range(0, 9) < 4;
                clr_btn  = $urandom_range(0, 9) < 2;
                len = $urandom_range(1, 150);
                repeat (len) @(negedge clk);
            end
        end
        quiet(100);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
